vga_timing_gen: RTL and testbench

//   Parametrised VGA raster timing generator. Derives a pixel-clock enable from the system

---
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 tb/tb_vga_timing_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel-clock divider and delayed sync/blank pipeline
module vga_timing_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DEPTH = 2,
  parameter int HW         = 10,
  parameter int VW         = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic          vga_clk,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          vga_blank_n,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      pix_ce  <= 1'b0;
      vga_clk <= 1'b0;
    end else if (en) begin
      div     <= (div == DIV_LAST) ? '0 : div + DW'(1);
      pix_ce  <= (div == DIV_LAST);
      vga_clk <= (div >= DIV_HALF);
    end else begin
      pix_ce  <= 1'b0;
    end
  end

  logic h_wrap;
  logic v_wrap;
  assign h_wrap = (hcount == H_LAST);
  assign v_wrap = (vcount == V_LAST);

  // A tick already issued on pix_ce is always consumed, so dropping en never loses one.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= pix_ce && h_wrap;
      frame_start <= pix_ce && h_wrap && v_wrap;
      if (pix_ce) begin
        hcount <= h_wrap ? '0 : hcount + HW'(1);
        if (h_wrap) begin
          vcount <= v_wrap ? '0 : vcount + VW'(1);
        end
      end
    end
  end

  logic hs;
  logic vs;
  logic vis;
  assign hs  = (hcount >= HS_START) && (hcount < HS_END);
  assign vs  = (vcount >= VS_START) && (vcount < VS_END);
  assign vis = (hcount < H_VIS) && (vcount < V_VIS);

  logic [PIPE_DEPTH-1:0] hs_q;
  logic [PIPE_DEPTH-1:0] vs_q;
  logic [PIPE_DEPTH-1:0] vis_q;
  logic [PIPE_DEPTH:0]   hs_cat;
  logic [PIPE_DEPTH:0]   vs_cat;
  logic [PIPE_DEPTH:0]   vis_cat;
  assign hs_cat  = {hs_q, hs};
  assign vs_cat  = {vs_q, vs};
  assign vis_cat = {vis_q, vis};

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q  <= '0;
      vs_q  <= '0;
      vis_q <= '0;
    end else if (pix_ce) begin
      hs_q  <= hs_cat[PIPE_DEPTH-1:0];
      vs_q  <= vs_cat[PIPE_DEPTH-1:0];
      vis_q <= vis_cat[PIPE_DEPTH-1:0];
    end
  end

  assign hsync       = hs_q[PIPE_DEPTH-1] ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = vs_q[PIPE_DEPTH-1] ? VSYNC_POL : ~VSYNC_POL;
  assign vga_blank_n = vis_q[PIPE_DEPTH-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - checks two vga_timing_gen configurations against a tick-count raster model
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, en_a = 1'b0, rst_b = 1'b1, en_b = 1'b0;

  logic       pix_ce_a, vga_clk_a, hsync_a, vsync_a, blank_a, ls_a, fs_a;
  logic [9:0] hcount_a, vcount_a;
  logic       pix_ce_b, vga_clk_b, hsync_b, vsync_b, blank_b, ls_b, fs_b;
  logic [3:0] hcount_b, vcount_b;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .pix_ce(pix_ce_a), .vga_clk(vga_clk_a),
    .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
    .vga_blank_n(blank_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DEPTH(3), .HW(4), .VW(4)
  ) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .pix_ce(pix_ce_b), .vga_clk(vga_clk_b),
    .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
    .vga_blank_n(blank_b), .line_start(ls_b), .frame_start(fs_b)
  );

  // Mode table per configuration: index 0 = defaults, 1 = small mode
  int D   [2] = '{2, 3};
  int HA  [2] = '{640, 4};
  int HFP [2] = '{16, 1};
  int HSY [2] = '{96, 2};
  int HT  [2] = '{800, 8};
  int VA  [2] = '{480, 3};
  int VFP [2] = '{10, 1};
  int VSY [2] = '{2, 1};
  int VT  [2] = '{525, 6};
  bit PH  [2] = '{1'b0, 1'b1};
  bit PV  [2] = '{1'b0, 1'b1};
  int P   [2] = '{2, 3};

  // Model state: the raster position is just the number of pixel ticks since reset
  int     m_div  [2];
  bit     m_pce  [2];
  bit     m_vclk [2];
  bit     m_ls   [2];
  bit     m_fs   [2];
  longint m_t    [2];

  int checks = 0;
  int passes = 0;
  int ncyc   = 0;
  logic prev_hs_a, prev_hs_b;
  logic [3:0] prev_vc_b;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, ncyc);
  endtask

  task automatic model_step(int i, bit r, bit e);
    bit wrap_h;
    if (r) begin
      m_div[i] = 0; m_pce[i] = 0; m_vclk[i] = 0; m_ls[i] = 0; m_fs[i] = 0; m_t[i] = 0;
    end else begin
      wrap_h  = m_pce[i] && ((m_t[i] % HT[i]) == HT[i] - 1);
      m_ls[i] = wrap_h;
      m_fs[i] = wrap_h && (((m_t[i] / HT[i]) % VT[i]) == VT[i] - 1);
      if (m_pce[i]) m_t[i]++;
      if (e) begin
        m_pce[i]  = (m_div[i] == D[i] - 1);
        m_vclk[i] = (m_div[i] >= D[i] / 2);
        m_div[i]  = (m_div[i] + 1) % D[i];
      end else begin
        m_pce[i] = 0;
      end
    end
  endtask

  task automatic cmp(int i, longint pce, longint vclk, longint hc, longint vc,
                     longint hs, longint vs, longint bl, longint ls, longint fs);
    string  pre;
    longint t, tt, hce, vce;
    bit     ehs, evs, evis;
    pre = (i == 0) ? "A." : "B.";
    t   = m_t[i];
    ehs = 0; evs = 0; evis = 0;
    if (t >= P[i]) begin
      tt   = t - P[i];
      hce  = tt % HT[i];
      vce  = (tt / HT[i]) % VT[i];
      ehs  = (hce >= HA[i] + HFP[i]) && (hce < HA[i] + HFP[i] + HSY[i]);
      evs  = (vce >= VA[i] + VFP[i]) && (vce < VA[i] + VFP[i] + VSY[i]);
      evis = (hce < HA[i]) && (vce < VA[i]);
    end
    chk({pre, "pix_ce"}, pce, m_pce[i]);
    chk({pre, "vga_clk"}, vclk, m_vclk[i]);
    chk({pre, "hcount"}, hc, t % HT[i]);
    chk({pre, "vcount"}, vc, (t / HT[i]) % VT[i]);
    chk({pre, "hsync"}, hs, ehs ? PH[i] : !PH[i]);
    chk({pre, "vsync"}, vs, evs ? PV[i] : !PV[i]);
    chk({pre, "blank_n"}, bl, evis);
    chk({pre, "line_start"}, ls, m_ls[i]);
    chk({pre, "frame_start"}, fs, m_fs[i]);
  endtask

  task automatic cyc();
    prev_hs_a = hsync_a;
    prev_hs_b = hsync_b;
    prev_vc_b = vcount_b;
    @(posedge clk);
    model_step(0, rst_a, en_a);
    model_step(1, rst_b, en_b);
    #1;
    cmp(0, pix_ce_a, vga_clk_a, hcount_a, vcount_a, hsync_a, vsync_a, blank_a, ls_a, fs_a);
    cmp(1, pix_ce_b, vga_clk_b, hcount_b, vcount_b, hsync_b, vsync_b, blank_b, ls_b, fs_b);
    ncyc++;
  endtask

  initial begin
    int n, t1, cnt;
    rst_a = 1; rst_b = 1; en_a = 1; en_b = 1;
    repeat (3) cyc();
    chk("A.rst_hcount", hcount_a, 0);
    chk("A.rst_hsync", hsync_a, 1);
    chk("A.rst_blank", blank_a, 0);
    chk("A.rst_vga_clk", vga_clk_a, 0);
    chk("B.rst_hsync", hsync_b, 0);
    rst_a = 0; rst_b = 0;

    n = 0;
    while (!ls_a && n < 5000) begin cyc(); n++; end
    chk("A.first_line_start_cycle", n, 1601);

    n = 0;
    while (!(prev_hs_a && !hsync_a) && n < 4000) begin cyc(); n++; end
    chk("A.hsync_fall_seen", n < 4000, 1);
    chk("A.hsync_fall_hcount", hcount_a, 658);
    t1 = ncyc;
    n = 0;
    while (!(!prev_hs_a && hsync_a) && n < 4000) begin cyc(); n++; end
    chk("A.hsync_low_clk", ncyc - t1, 192);
    n = 0;
    while (!(prev_hs_a && !hsync_a) && n < 4000) begin cyc(); n++; end
    chk("A.hsync_period_clk", ncyc - t1, 1600);
    t1 = ncyc;

    n = 0;
    while (hcount_a != 100 && n < 4000) begin cyc(); n++; end
    en_a = 0;
    repeat (37) cyc();
    chk("A.frozen_hcount", hcount_a, 100);
    en_a = 1;
    n = 0;
    while (!(prev_hs_a && !hsync_a) && n < 4000) begin cyc(); n++; end
    chk("A.hsync_period_paused_clk", ncyc - t1, 1637);

    n = 0;
    while (!ls_a && n < 4000) begin cyc(); n++; end
    cnt = 0; n = 0;
    do begin cyc(); n++; if (blank_a) cnt++; end while (!ls_a && n < 4000);
    chk("A.blank_high_clk_per_line", cnt, 1280);

    n = 0;
    while (hcount_a != 300 && n < 4000) begin cyc(); n++; end
    rst_a = 1;
    cyc();
    chk("A.midline_rst_hcount", hcount_a, 0);
    chk("A.midline_rst_vcount", vcount_a, 0);
    chk("A.midline_rst_hsync", hsync_a, 1);
    chk("A.midline_rst_blank", blank_a, 0);
    rst_a = 0;

    rst_b = 1;
    cyc();
    rst_b = 0;
    n = 0;
    while (!fs_b && n < 1000) begin cyc(); n++; end
    chk("B.first_frame_start_cycle", n, 145);
    chk("B.frame_start_hcount", hcount_b, 0);
    chk("B.frame_start_vcount", vcount_b, 0);
    chk("B.vcount_before_wrap", prev_vc_b, 5);
    t1 = ncyc;
    n = 0;
    do begin cyc(); n++; end while (!fs_b && n < 1000);
    chk("B.frame_period_clk", ncyc - t1, 144);

    n = 0;
    while (!pix_ce_b && n < 100) begin cyc(); n++; end
    t1 = ncyc;
    n = 0;
    do begin cyc(); n++; end while (!pix_ce_b && n < 100);
    chk("B.pix_ce_period", ncyc - t1, 3);

    n = 0;
    while (!(!prev_hs_b && hsync_b) && n < 200) begin cyc(); n++; end
    chk("B.hsync_rise_hcount", hcount_b, 0);
    t1 = ncyc;
    n = 0;
    while (!(prev_hs_b && !hsync_b) && n < 200) begin cyc(); n++; end
    chk("B.hsync_high_clk", ncyc - t1, 6);

    for (int k = 0; k < 6000; k++) begin
      en_a  = ($urandom_range(0, 7) != 0);
      en_b  = ($urandom_range(0, 5) != 0);
      rst_a = ($urandom_range(0, 1999) == 0);
      rst_b = ($urandom_range(0, 499) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
